// File: rtl/redmule_mesh_stdio_mon.sv
// ----------------------------------------------------------------------------
// redmule_mesh_stdio_mon
//
// Passive AXI write monitor that sits on the L2 side of the tiles-to-L2 AXI
// multiplexer, next to the L2 simulation memory. It never drives a ready; it
// only watches AW and W handshakes.
//
// Every AW handshake is queued in order. The W tracker takes beat 0 of each
// burst and looks at the queued AW to decide what the beat means:
//   - STDOUT burst: the first enabled byte becomes a character on the
//     output stream, tagged with the writer's AXI ID.
//   - STDERR burst: the first enabled byte is latched as the exit code.
//   - anything else: ignored.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   aw_valid_i/aw_ready_i   observed AW handshake
//   aw_addr_i/id_i/len_i    observed AW payload
//   w_valid_i/w_ready_i     observed W handshake
//   w_data_i/strb_i/last_i  observed W payload
//   char_valid_o/ready_i    character stream handshake (valid/ready)
//   char_data_o/id_o/eol_o  character byte, writer ID, byte == 0x0A
//   err_valid_o/err_code_o  sticky "exit code seen" flag and last exit code
//   drop_cnt_o              saturating count of characters lost to a full FIFO
//   aw_overflow_o           sticky: AW seen while the AW queue was full
//   w_orphan_o              sticky: W seen with no AW to pair it with
// ----------------------------------------------------------------------------
module redmule_mesh_stdio_mon #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                ID_W        = 4,
    parameter int                AW_DEPTH    = 8,
    parameter int                OUT_DEPTH   = 16,
    parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'h2FFF_0000,
    parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'h2FFF_0004
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              aw_valid_i,
    input  logic              aw_ready_i,
    input  logic [ADDR_W-1:0] aw_addr_i,
    input  logic [ID_W-1:0]   aw_id_i,
    input  logic [7:0]        aw_len_i,
    input  logic              w_valid_i,
    input  logic              w_ready_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic              w_last_i,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    output logic [7:0]        char_data_o,
    output logic [ID_W-1:0]   char_id_o,
    output logic              char_eol_o,
    output logic              err_valid_o,
    output logic [7:0]        err_code_o,
    output logic [15:0]       drop_cnt_o,
    output logic              aw_overflow_o,
    output logic              w_orphan_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int AW_PW  = $clog2(AW_DEPTH);
    localparam int OUT_PW = $clog2(OUT_DEPTH);
    localparam logic [AW_PW:0]  AW_FULL_CNT  = (AW_PW + 1)'(AW_DEPTH);
    localparam logic [OUT_PW:0] OUT_FULL_CNT = (OUT_PW + 1)'(OUT_DEPTH);

    localparam logic [1:0] CLS_OTHER  = 2'd0;
    localparam logic [1:0] CLS_STDOUT = 2'd1;
    localparam logic [1:0] CLS_STDERR = 2'd2;

    typedef enum logic {
        W_FIRST,
        W_REST
    } w_state_t;

    w_state_t r_state, w_state_next;

    // ------------------------------------------------------------------
    // Handshakes and address classification
    // ------------------------------------------------------------------
    logic       w_aw_hs, w_w_hs;
    logic [1:0] w_in_cls;

    assign w_aw_hs  = aw_valid_i & aw_ready_i;
    assign w_w_hs   = w_valid_i & w_ready_i;
    assign w_in_cls = (aw_addr_i == STDOUT_ADDR) ? CLS_STDOUT :
                      (aw_addr_i == STDERR_ADDR) ? CLS_STDERR : CLS_OTHER;

    // ------------------------------------------------------------------
    // Outstanding-AW queue
    // ------------------------------------------------------------------
    logic [1:0]       r_aw_cls [AW_DEPTH];
    logic [ID_W-1:0]  r_aw_id  [AW_DEPTH];
    logic [7:0]       r_aw_len [AW_DEPTH];
    logic [AW_PW-1:0] r_aw_wr_ptr, r_aw_rd_ptr;
    logic [AW_PW:0]   r_aw_cnt;

    logic w_aw_empty, w_aw_full;
    logic w_aw_pop, w_aw_push, w_aw_push_req, w_aw_ovf;
    logic w_beat0, w_bypass, w_orphan;

    assign w_aw_empty = (r_aw_cnt == '0);
    assign w_aw_full  = (r_aw_cnt == AW_FULL_CNT);

    // Beat 0 needs either a queued AW or one arriving in the same cycle.
    assign w_beat0  = (r_state == W_FIRST) & w_w_hs & (!w_aw_empty | w_aw_hs);
    assign w_bypass = (r_state == W_FIRST) & w_w_hs & w_aw_empty & w_aw_hs;
    assign w_orphan = (r_state == W_FIRST) & w_w_hs & w_aw_empty & !w_aw_hs;

    // The head is retired on the last beat of its burst; a bypassed
    // single-beat burst never enters the queue at all.
    assign w_aw_pop      = w_w_hs & w_last_i & !w_aw_empty;
    assign w_aw_push_req = w_aw_hs & !(w_bypass & w_last_i);
    assign w_aw_ovf      = w_aw_push_req & w_aw_full & !w_aw_pop;
    assign w_aw_push     = w_aw_push_req & !w_aw_ovf;

    // Burst boundaries come from w_last; the queued length is kept with the
    // entry but nothing downstream consumes it.
    logic w_unused_len;
    assign w_unused_len = ^{aw_len_i, r_aw_len[r_aw_rd_ptr]};

    always_ff @(posedge clk_i) begin
        if (w_aw_push) begin
            r_aw_cls[r_aw_wr_ptr] <= w_in_cls;
            r_aw_id[r_aw_wr_ptr]  <= aw_id_i;
            r_aw_len[r_aw_wr_ptr] <= aw_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_wr_ptr <= '0;
            r_aw_rd_ptr <= '0;
            r_aw_cnt    <= '0;
        end else begin
            if (w_aw_push) r_aw_wr_ptr <= r_aw_wr_ptr + 1'b1;
            if (w_aw_pop)  r_aw_rd_ptr <= r_aw_rd_ptr + 1'b1;
            case ({w_aw_push, w_aw_pop})
                2'b10:   r_aw_cnt <= r_aw_cnt + 1'b1;
                2'b01:   r_aw_cnt <= r_aw_cnt - 1'b1;
                default: r_aw_cnt <= r_aw_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // W tracker FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= W_FIRST;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            W_FIRST: if (w_beat0 && !w_last_i) w_state_next = W_REST;
            W_REST:  if (w_w_hs && w_last_i)   w_state_next = W_FIRST;
            default: w_state_next = W_FIRST;
        endcase
    end

    // ------------------------------------------------------------------
    // Character extraction from beat 0
    // ------------------------------------------------------------------
    logic [1:0]      w_cur_cls;
    logic [ID_W-1:0] w_cur_id;
    logic [7:0]      w_lane [STRB_W];
    logic [7:0]      w_sel_byte;
    logic            w_sel_found;
    logic            w_char_ok;

    // A queued AW is always older than one arriving now, so it wins.
    assign w_cur_cls = w_aw_empty ? w_in_cls : r_aw_cls[r_aw_rd_ptr];
    assign w_cur_id  = w_aw_empty ? aw_id_i  : r_aw_id[r_aw_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign w_lane[gi] = w_data_i[gi*8 +: 8];
        end
    endgenerate

    // Scan from the top lane down so the lowest enabled lane is what remains.
    always_comb begin
        w_sel_byte  = 8'h00;
        w_sel_found = 1'b0;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (w_strb_i[i]) begin
                w_sel_byte  = w_lane[i];
                w_sel_found = 1'b1;
            end
        end
    end

    assign w_char_ok = w_beat0 & w_sel_found & (w_sel_byte != 8'h00);

    // ------------------------------------------------------------------
    // Character output FIFO
    // ------------------------------------------------------------------
    logic [7:0]        r_out_data [OUT_DEPTH];
    logic [ID_W-1:0]   r_out_id   [OUT_DEPTH];
    logic              r_out_eol  [OUT_DEPTH];
    logic [OUT_PW-1:0] r_out_wr_ptr, r_out_rd_ptr;
    logic [OUT_PW:0]   r_out_cnt;

    logic w_out_push_req, w_out_push, w_out_pop, w_out_drop, w_out_valid;

    assign w_out_valid    = (r_out_cnt != '0);
    assign w_out_pop      = w_out_valid & char_ready_i;
    assign w_out_push_req = w_char_ok & (w_cur_cls == CLS_STDOUT);
    // A pop in the same cycle frees the slot, so a full FIFO only drops
    // when the consumer is not taking a character.
    assign w_out_drop     = w_out_push_req & (r_out_cnt == OUT_FULL_CNT) & !w_out_pop;
    assign w_out_push     = w_out_push_req & !w_out_drop;

    always_ff @(posedge clk_i) begin
        if (w_out_push) begin
            r_out_data[r_out_wr_ptr] <= w_sel_byte;
            r_out_id[r_out_wr_ptr]   <= w_cur_id;
            r_out_eol[r_out_wr_ptr]  <= (w_sel_byte == 8'h0A);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_wr_ptr <= '0;
            r_out_rd_ptr <= '0;
            r_out_cnt    <= '0;
        end else begin
            if (w_out_push) r_out_wr_ptr <= r_out_wr_ptr + 1'b1;
            if (w_out_pop)  r_out_rd_ptr <= r_out_rd_ptr + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Storage is not reset, so the payload is masked while nothing is valid.
    assign char_valid_o = w_out_valid;
    assign char_data_o  = w_out_valid ? r_out_data[r_out_rd_ptr] : 8'h00;
    assign char_id_o    = w_out_valid ? r_out_id[r_out_rd_ptr]   : '0;
    assign char_eol_o   = w_out_valid & r_out_eol[r_out_rd_ptr];

    // ------------------------------------------------------------------
    // Exit code and status
    // ------------------------------------------------------------------
    logic        r_err_valid;
    logic [7:0]  r_err_code;
    logic [15:0] r_drop_cnt;
    logic        r_aw_overflow;
    logic        r_w_orphan;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_valid   <= 1'b0;
            r_err_code    <= 8'h00;
            r_drop_cnt    <= 16'h0000;
            r_aw_overflow <= 1'b0;
            r_w_orphan    <= 1'b0;
        end else begin
            if (w_char_ok && (w_cur_cls == CLS_STDERR)) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_sel_byte;
            end
            if (w_out_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_aw_ovf) r_aw_overflow <= 1'b1;
            if (w_orphan) r_w_orphan    <= 1'b1;
        end
    end

    assign err_valid_o   = r_err_valid;
    assign err_code_o    = r_err_code;
    assign drop_cnt_o    = r_drop_cnt;
    assign aw_overflow_o = r_aw_overflow;
    assign w_orphan_o    = r_w_orphan;

endmodule

// File: tb/tb_redmule_mesh_stdio_mon.sv
// ----------------------------------------------------------------------------
// tb_redmule_mesh_stdio_mon
//
// Drives AW/W traffic into the monitor. Expected characters are queued when
// the W beat is driven and checked when the DUT hands a character over.
// ----------------------------------------------------------------------------
module tb_redmule_mesh_stdio_mon;

    localparam logic [31:0] STDERR_A = 32'h2FFF_0000;
    localparam logic [31:0] STDOUT_A = 32'h2FFF_0004;
    localparam logic [31:0] OTHER_A  = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        aw_valid_i = 1'b0, aw_ready_i = 1'b0;
    logic [31:0] aw_addr_i = '0;
    logic [3:0]  aw_id_i = '0;
    logic [7:0]  aw_len_i = '0;
    logic        w_valid_i = 1'b0, w_ready_i = 1'b0;
    logic [31:0] w_data_i = '0;
    logic [3:0]  w_strb_i = '0;
    logic        w_last_i = 1'b0;
    logic        char_valid_o, char_ready_i = 1'b1;
    logic [7:0]  char_data_o;
    logic [3:0]  char_id_o;
    logic        char_eol_o;
    logic        err_valid_o;
    logic [7:0]  err_code_o;
    logic [15:0] drop_cnt_o;
    logic        aw_overflow_o, w_orphan_o;

    redmule_mesh_stdio_mon dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i),
        .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i), .aw_len_i(aw_len_i),
        .w_valid_i(w_valid_i), .w_ready_i(w_ready_i),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .char_valid_o(char_valid_o), .char_ready_i(char_ready_i),
        .char_data_o(char_data_o), .char_id_o(char_id_o), .char_eol_o(char_eol_o),
        .err_valid_o(err_valid_o), .err_code_o(err_code_o),
        .drop_cnt_o(drop_cnt_o),
        .aw_overflow_o(aw_overflow_o), .w_orphan_o(w_orphan_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] id;
        logic       eol;
    } chr_t;

    chr_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] id);
        chr_t e;
        e.d   = d;
        e.id  = id;
        e.eol = (d == 8'h0A);
        exp_q.push_back(e);
    endtask

    // Character consumer side: compare each accepted character, and check
    // the payload holds while it is stalled.
    chr_t held_val;
    logic held = 1'b0;
    always @(negedge clk) begin
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (char_valid_o && held) begin
                chk("stable", {23'd0, char_data_o, char_id_o, char_eol_o},
                    {23'd0, held_val});
            end
            if (char_valid_o && char_ready_i) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("char_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    chr_t e;
                    e = exp_q.pop_front();
                    chk("char_data", {24'd0, char_data_o}, {24'd0, e.d});
                    chk("char_id",   {28'd0, char_id_o},   {28'd0, e.id});
                    chk("char_eol",  {31'd0, char_eol_o},  {31'd0, e.eol});
                end
            end else if (char_valid_o) begin
                held     = 1'b1;
                held_val = {char_data_o, char_id_o, char_eol_o};
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1;
        aw_addr_i = a; aw_id_i = id; aw_len_i = len;
        @(posedge clk); #1;
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        w_valid_i = 1'b1; w_ready_i = 1'b1;
        w_data_i = d; w_strb_i = s; w_last_i = last;
        @(posedge clk); #1;
        w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0;
    endtask

    task automatic do_aw_w(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1;
        aw_addr_i = a; aw_id_i = id; aw_len_i = 8'd0;
        w_valid_i = 1'b1; w_ready_i = 1'b1;
        w_data_i = d; w_strb_i = 4'hF; w_last_i = 1'b1;
        @(posedge clk); #1;
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cv"},  {31'd0, char_valid_o}, 32'd0);
        chk({tag, "_cd"},  {24'd0, char_data_o},  32'd0);
        chk({tag, "_ci"},  {28'd0, char_id_o},    32'd0);
        chk({tag, "_ce"},  {31'd0, char_eol_o},   32'd0);
        chk({tag, "_ev"},  {31'd0, err_valid_o},  32'd0);
        chk({tag, "_ec"},  {24'd0, err_code_o},   32'd0);
        chk({tag, "_drp"}, {16'd0, drop_cnt_o},   32'd0);
        chk({tag, "_ovf"}, {31'd0, aw_overflow_o}, 32'd0);
        chk({tag, "_orp"}, {31'd0, w_orphan_o},   32'd0);
    endtask

    initial begin
        idle(3);
        chk_all_zero("reset");
        rst_i = 1'b0;
        idle(2);

        // Single character with one-cycle latency.
        do_aw(STDOUT_A, 4'd3, 8'd0);
        idle(2);
        push_exp(8'h48, 4'd3);
        do_w(32'h0000_0048, 4'b0001, 1'b1);
        chk("lat_valid", {31'd0, char_valid_o}, 32'd1);
        chk("lat_data",  {24'd0, char_data_o},  32'h48);
        wait_drain("drain_single");

        // Interleaved writers: only the two STDOUT bursts produce output.
        do_aw(STDOUT_A, 4'd1, 8'd0);
        do_aw(OTHER_A,  4'd2, 8'd3);
        do_aw(STDOUT_A, 4'd5, 8'd0);
        push_exp(8'h41, 4'd1);
        do_w(32'h0000_0041, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) do_w(32'h0000_007F, 4'hF, i == 3);
        push_exp(8'h0A, 4'd5);
        do_w(32'h0000_000A, 4'hF, 1'b1);
        wait_drain("drain_interleave");

        // Exit code capture and overwrite.
        do_aw(STDERR_A, 4'd0, 8'd0);
        do_w(32'h0000_0003, 4'hF, 1'b1);
        chk("err_valid", {31'd0, err_valid_o}, 32'd1);
        chk("err_code3", {24'd0, err_code_o},  32'd3);
        do_aw(STDERR_A, 4'd0, 8'd0);
        do_w(32'h0000_0007, 4'hF, 1'b1);
        chk("err_code7", {24'd0, err_code_o},  32'd7);

        // Lowest enabled lane selects the byte; a zero byte is ignored.
        do_aw(STDOUT_A, 4'd4, 8'd0);
        push_exp(8'h63, 4'd4);
        do_w(32'h6162_6364, 4'b0110, 1'b1);
        do_aw(STDOUT_A, 4'd4, 8'd0);
        do_w(32'h5500_0000, 4'b0001, 1'b1);
        wait_drain("drain_lanes");

        // Back-pressure: 16 buffered, 4 dropped, drained in order.
        char_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_aw(STDOUT_A, 4'(i), 8'd0);
            if (i < 16) push_exp(8'(8'h61 + i), 4'(i));
            do_w({24'd0, 8'(8'h61 + i)}, 4'b0001, 1'b1);
        end
        chk("drop_cnt", {16'd0, drop_cnt_o}, 32'd4);
        idle(4);
        chk("bp_head", {24'd0, char_data_o}, 32'h61);
        char_ready_i = 1'b1;
        wait_drain("drain_bp");

        // Same-cycle AW and W with an empty queue.
        push_exp(8'h42, 4'd2);
        do_aw_w(STDOUT_A, 4'd2, 32'h0000_0042);
        wait_drain("drain_bypass");

        // W with nothing tracked.
        chk("orphan_pre", {31'd0, w_orphan_o}, 32'd0);
        do_w(32'h0000_0055, 4'hF, 1'b1);
        chk("orphan", {31'd0, w_orphan_o}, 32'd1);
        idle(2);
        chk("orphan_nochar", {31'd0, char_valid_o}, 32'd0);

        // Asynchronous reset in the middle of a STDOUT burst.
        char_ready_i = 1'b0;
        do_aw(STDOUT_A, 4'd6, 8'd3);
        do_w(32'h0000_0033, 4'hF, 1'b0);
        do_w(32'h0000_0034, 4'hF, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        idle(2);
        rst_i = 1'b0;
        char_ready_i = 1'b1;
        idle(1);
        do_aw(STDOUT_A, 4'd7, 8'd0);
        push_exp(8'h5A, 4'd7);
        do_w(32'h0000_005A, 4'hF, 1'b1);
        wait_drain("drain_after_rst");

        // AW queue overflow on the ninth outstanding AW.
        for (int i = 0; i < 8; i++) do_aw(OTHER_A, 4'(i), 8'd0);
        chk("ovf_pre", {31'd0, aw_overflow_o}, 32'd0);
        do_aw(OTHER_A, 4'd8, 8'd0);
        chk("ovf", {31'd0, aw_overflow_o}, 32'd1);

        idle(3);
        chk("q_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/redmule_mesh_stdio_mon.md
# redmule_mesh_stdio_mon

Passive AXI write monitor on the L2 side of the tiles-to-L2 AXI multiplexer, in parallel with the L2 simulation memory. It correctly pairs every write data beat with its address by tracking outstanding AW transactions in order. It extracts characters written to the stdout address into a buffered stream tagged with the AXI ID, and latches the exit code written to the stderr address. It never drives `aw_ready`/`w_ready`; it only observes handshakes.

## Interface

Parameters:
- `ADDR_W`, default 32: AW address width.
- `DATA_W`, default 32: W data width. Must be a multiple of 8.
- `ID_W`, default 4: AXI ID width at the L2 port.
- `AW_DEPTH`, default 8: outstanding-AW tracking FIFO depth. Power of 2.
- `OUT_DEPTH`, default 16: character output FIFO depth. Power of 2.
- `STDERR_ADDR`, default 32'h2FFF_0000: exit-code address.
- `STDOUT_ADDR`, default 32'h2FFF_0004: character address.

Ports:
- `clk_i` in 1: clock. Decided: one clock domain.
- `rst_i` in 1: reset. Decided: asynchronous, active-high.
- `aw_valid_i` / `aw_ready_i` in 1 each: observed AW handshake.
- `aw_addr_i` in ADDR_W: observed AW address.
- `aw_id_i` in ID_W: observed AW ID.
- `aw_len_i` in 8: observed AW burst length minus one.
- `w_valid_i` / `w_ready_i` in 1 each: observed W handshake.
- `w_data_i` in DATA_W: observed W data.
- `w_strb_i` in DATA_W/8: observed W strobe.
- `w_last_i` in 1: observed W last beat.
- `char_valid_o` out 1: character available.
- `char_ready_i` in 1: consumer accepts the character.
- `char_data_o` out 8: character byte.
- `char_id_o` out ID_W: AXI ID of the writer.
- `char_eol_o` out 1: character is 0x0A.
- `err_valid_o` out 1: exit code captured (sticky).
- `err_code_o` out 8: last captured exit code.
- `drop_cnt_o` out 16: characters dropped because the output FIFO was full (saturating).
- `aw_overflow_o` out 1: sticky; an AW handshake occurred while the AW FIFO was full.
- `w_orphan_o` out 1: sticky; a W handshake occurred with no AW tracked.

## Operation

- AW tracking:
  - Each AW handshake (`aw_valid_i & aw_ready_i`) pushes {class, id, len} into the AW FIFO.
  - Class is STDOUT if `aw_addr_i == STDOUT_ADDR`, STDERR if `aw_addr_i == STDERR_ADDR`, otherwise OTHER.
  - Every AW is pushed, because W order follows AW order at a single AXI port.
- W tracker, two-state FSM:
  - W_FIRST: the next W handshake is beat 0 of the burst at the AW FIFO head. If the beat is `w_last_i`, pop the head and stay in W_FIRST; otherwise go to W_REST.
  - W_REST: the head's class, ID and length are held. Pop the head on the beat with `w_last_i` and return to W_FIRST.
- Character extraction, beat 0 of STDOUT/STDERR bursts only:
  - The byte is the lowest byte lane with its strobe set.
  - A beat with no strobe set, or an extracted byte of 0x00, is ignored.
- STDOUT beat: push {byte, id, byte==0x0A} into the output FIFO.
  - If the output FIFO is full, drop the byte and increment `drop_cnt_o`, saturating at 16'hFFFF.
- STDERR beat: `err_code_o` takes the byte and `err_valid_o` is set. A later STDERR write overwrites the code.
- Simultaneous AW and W handshakes with the AW FIFO empty: the W beat uses the incoming AW directly (bypass). Nothing is pushed if that beat is also `w_last_i`.
- W handshake with the AW FIFO empty and no concurrent AW: set `w_orphan_o` and ignore the beat. The FSM stays in W_FIRST.
- AW handshake with the AW FIFO full and no same-cycle pop: set `aw_overflow_o` and discard the AW. A same-cycle pop makes room, so no overflow occurs in that case. Pairing after an overflow is undefined until reset.
- Output stream uses standard valid/ready:
  - `char_data_o`, `char_id_o` and `char_eol_o` must stay stable while `char_valid_o=1` and `char_ready_i=0`.
  - A push and a pop in the same cycle on a full output FIFO is not a drop; the FIFO is treated as full only after the pop.

## Timing

- Reset values: all outputs 0, both FIFOs empty, FSM in W_FIRST.
- Reset is asynchronous and takes effect mid-burst. Partially tracked bursts are discarded.
- Character latency: `char_valid_o` rises the cycle after the W handshake when the output FIFO was empty. This gives 1-cycle registered latency with no combinational path from `w_*` to `char_*`.
- `err_valid_o` and `err_code_o` update the cycle after the STDERR beat-0 handshake.
- The AW FIFO accepts one push and one pop per cycle. The output FIFO accepts one push and one pop per cycle.
- `drop_cnt_o`, `aw_overflow_o` and `w_orphan_o` update the cycle after the causing event.

## Test plan

- AW to 32'h2FFF0004 with id=3 and len=0, then W data=0x48 with strb=4'b0001 two cycles later -> after 1 cycle, `char_valid_o`=1, `char_data_o`=0x48, `char_id_o`=3, `char_eol_o`=0.
- Interleaved writers: AW(0x2FFF0004, id=1), AW(0x1C00_0000, id=2, len=3), AW(0x2FFF0004, id=5), then W beats in order 0x41, 4×0x7F, 0x0A -> exactly two characters out: (0x41, id 1), then (0x0A, id 5, eol=1). The 0x7F beats are not emitted.
- AW to 32'h2FFF0000 with W data=0x00000003 -> `err_valid_o`=1 and `err_code_o`=3 one cycle later. A second write of 0x07 -> `err_code_o`=7.
- Hold `char_ready_i`=0 and issue 20 STDOUT writes -> 16 characters buffered, `drop_cnt_o`=4. Outputs stay stable until `char_ready_i` rises, then drain in order.
- Same-cycle AW(STDOUT, id=2, len=0) and W(0x42, last) with empty FIFO -> character 0x42 with id 2 out. A W with no AW -> `w_orphan_o`=1. 9 AWs with no W -> `aw_overflow_o`=1.
- Assert `rst_i` during a 4-beat STDOUT burst after beat 1 -> all outputs 0 immediately. A subsequent single-beat STDOUT write of 0x5A is emitted correctly.
